nonlin_part_pipe: RTL

- Parametrised, pipelined, elastic successor of the combinational non-linear stage of the linearised ripple-carry adder.
- Computes the AND-term vector nl from operands a, b and the semi-carry vector r supplied by the linear part.
- Carries results through a STAGES-deep valid/ready pipeline with full backpressure.
- Adds per-transaction fault injection, used by the error-detection experiments, and a delivered-transaction counter.

---
 rtl/nonlin_part_pipe_pkg.sv | 23 ++
 rtl/nonlin_part_pipe_nonlin_terms.sv | 27 ++
 rtl/nonlin_part_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nonlin_part_pipe_pkg.sv
// Shared constants for the non-linear adder stage: default adder width and the
// width helpers that every file derives its port sizes from.
package nonlin_part_pipe_pkg;

  localparam int NBIT = 8;

  function automatic int nlw_of(input int nbit);
    return 3 * nbit - 5;
  endfunction

  function automatic int rw_of(input int nbit);
    return nbit - 3;
  endfunction

  function automatic int opw_of(input int nbit);
    return nbit - 1;
  endfunction

  localparam int NLW = nlw_of(NBIT);
  localparam int RW  = rw_of(NBIT);
  localparam int OPW = opw_of(NBIT);

endpackage

// File: rtl/nonlin_part_pipe_nonlin_terms.sv
// Combinational AND-term generator of the linearised ripple-carry adder:
// low bits come straight from the operands, upper bits pair each operand with a semi-carry.
module nonlin_terms
  import nonlin_part_pipe_pkg::*;
#(
  parameter int NBIT = nonlin_part_pipe_pkg::NBIT
) (
  input  logic [opw_of(NBIT)-1:0] a,
  input  logic [opw_of(NBIT)-1:0] b,
  input  logic [rw_of(NBIT)-1:0]  r,
  output logic [nlw_of(NBIT)-1:0] nl
);

  always_comb begin
    nl    = '0;
    nl[0] = a[0] & b[0];
    nl[1] = a[1] & b[1];
    nl[2] = a[1] & a[0] & b[0];
    nl[3] = b[1] & a[0] & b[0];
    for (int i = 2; i <= NBIT - 2; i++) begin
      nl[3*i-2] = a[i] & b[i];
      nl[3*i-1] = a[i] & r[i-2];
      nl[3*i]   = b[i] & r[i-2];
    end
  end

endmodule

// File: rtl/nonlin_part_pipe.sv
// Elastic valid/ready pipeline around the non-linear term generator, with
// per-transaction fault injection and a wrapping delivered-transaction counter.
module nonlin_part_pipe
  import nonlin_part_pipe_pkg::*;
#(
  parameter int NBIT   = nonlin_part_pipe_pkg::NBIT,
  parameter int STAGES = 2,
  parameter int CNTW   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [opw_of(NBIT)-1:0] a,
  input  logic [opw_of(NBIT)-1:0] b,
  input  logic [rw_of(NBIT)-1:0]  r,
  input  logic                    inj_en,
  input  logic [nlw_of(NBIT)-1:0] inj_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [nlw_of(NBIT)-1:0] nl,
  output logic                    out_inj,
  output logic [CNTW-1:0]         txn_cnt
);

  localparam int W_NL = nlw_of(NBIT);

  logic [W_NL-1:0]   terms;
  logic [W_NL-1:0]   cap_data;
  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] inj_vec;
  logic [W_NL-1:0]   data_vec [STAGES];
  logic [STAGES-1:0] adv;
  logic [CNTW-1:0]   txn_cnt_q;
  logic [CNTW-1:0]   txn_cnt_d;

  nonlin_terms #(.NBIT(NBIT)) u_terms (
    .a  (a),
    .b  (b),
    .r  (r),
    .nl (terms)
  );

  assign cap_data = terms ^ (inj_en ? inj_mask : '0);

  // A stage may load unless it and every stage below it are full and the sink is stalled.
  always_comb begin
    logic all_full;
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      all_full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        all_full = all_full & v_vec[j];
      end
      adv[k] = out_ready | ~all_full;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic            v_q, v_d;
    logic            inj_q, inj_d;
    logic [W_NL-1:0] data_q, data_d;
    logic            up_v, up_inj;
    logic [W_NL-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_v    = in_valid;
      assign up_inj  = inj_en;
      assign up_data = cap_data;
    end else begin : g_body
      assign up_v    = v_vec[k-1];
      assign up_inj  = inj_vec[k-1];
      assign up_data = data_vec[k-1];
    end

    always_comb begin
      v_d    = v_q;
      inj_d  = inj_q;
      data_d = data_q;
      if (adv[k]) begin
        v_d    = up_v;
        inj_d  = up_inj;
        data_d = up_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        inj_q  <= 1'b0;
        data_q <= '0;
      end else begin
        v_q    <= v_d;
        inj_q  <= inj_d;
        data_q <= data_d;
      end
    end

    assign v_vec[k]    = v_q;
    assign inj_vec[k]  = inj_q;
    assign data_vec[k] = data_q;
  end

  assign out_valid = v_vec[STAGES-1];
  assign out_inj   = inj_vec[STAGES-1];
  assign nl        = data_vec[STAGES-1];

  assign txn_cnt_d = txn_cnt_q + CNTW'(out_valid & out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_cnt_q <= '0;
    end else begin
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign txn_cnt = txn_cnt_q;

endmodule
